// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN arbitration-field deserializer:
//   - can_state_e     : deserializer state machine encoding
//   - CAN_*_W         : base / extended identifier widths
//   - CAN_STUFF_LIMIT : identical bits after which a stuff bit follows
//   - CAN_POS_*       : destuffed bit positions of SRR/RTR, IDE and extended RTR
//   - can_run_full()  : true when the run tracker says the next sample is stuffing
// -----------------------------------------------------------------------------
package can_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_BASE      = 3'd2,
    ST_EXT       = 3'd3,
    ST_DONE      = 3'd4
  } can_state_e;

  localparam int CAN_BASE_ID_W   = 11;
  localparam int CAN_EXT_ID_W    = 18;
  localparam int CAN_STUFF_LIMIT = 5;
  localparam int CAN_BIT_CNT_W   = 6;

  // Destuffed data-bit positions, counted from the first identifier bit
  localparam logic [CAN_BIT_CNT_W-1:0] CAN_POS_SRR     = 6'd11;
  localparam logic [CAN_BIT_CNT_W-1:0] CAN_POS_IDE     = 6'd12;
  localparam logic [CAN_BIT_CNT_W-1:0] CAN_POS_RTR_EXT = 6'd31;

  function automatic logic can_run_full(input logic [2:0] run);
    return (run == 3'(CAN_STUFF_LIMIT));
  endfunction

endpackage

// File: rtl/can_destuffer.sv
// -----------------------------------------------------------------------------
// can_destuffer
// Tracks the run of identical bits on the receive line and classifies each
// sample-point as a data bit or a stuff bit.
//
// Optional feature macro: CAN_STUFF_CHECK_EN
//   defined   -> o_stuff_viol flags a stuff bit equal to the preceding bit
//   undefined -> stuff bits are dropped unchecked, o_stuff_viol is 0
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_sp           : sample-point strobe
//   i_rx           : sampled receive line
//   i_seed         : SOF accepted this sample; seed tracker with last=0, run=1
//   i_active       : deserializer is inside the arbitration field
//   o_data_valid   : this sample is a data bit (not stuffing)
//   o_stuff_viol   : this sample is a stuff bit that violates the rule
// -----------------------------------------------------------------------------
module can_destuffer
  import can_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_sp,
  input  logic i_rx,
  input  logic i_seed,
  input  logic i_active,
  output logic o_data_valid,
  output logic o_stuff_viol
);

  logic       r_last;
  logic [2:0] r_run;
  logic       w_stuff_slot;

  // After CAN_STUFF_LIMIT identical bits the next sample is stuffing
  assign w_stuff_slot = can_run_full(r_run);

  // Run tracker: last bit value and length of the current run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b0;
      r_run  <= 3'd0;
    end else if (i_sp && i_seed) begin
      // The SOF itself is the first dominant bit of the first run
      r_last <= 1'b0;
      r_run  <= 3'd1;
    end else if (i_sp && i_active) begin
      if (w_stuff_slot) begin
        // A stuff bit starts a fresh run with its own value
        r_last <= i_rx;
        r_run  <= 3'd1;
      end else if (i_rx == r_last) begin
        r_run  <= r_run + 3'd1;
      end else begin
        r_last <= i_rx;
        r_run  <= 3'd1;
      end
    end
  end

  // Per-sample classification strobes
  always_comb begin
    o_data_valid = i_sp & i_active & ~w_stuff_slot;
`ifdef CAN_STUFF_CHECK_EN
    o_stuff_viol = i_sp & i_active & w_stuff_slot & (i_rx == r_last);
`else
    o_stuff_viol = 1'b0;
`endif
  end

endmodule

// File: rtl/can_arb_deserializer.sv
// -----------------------------------------------------------------------------
// can_arb_deserializer
// Front end of the CAN identifier block: waits for bus idle, detects SOF,
// removes stuff bits and shifts the arbitration field into parallel
// registers. F_IDF (active low) marks the captured field as valid.
//
// Optional feature macro: CAN_STUFF_CHECK_EN (stuff-violation detection;
// without it STUFF_ERR stays 0).
//
// Parameters:
//   IDLE_BITS : consecutive recessive samples needed before SOF is accepted
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high
//   SP        : sample-point strobe, one clk wide
//   RX        : receive line (0 dominant, 1 recessive)
//   IDF       : 11-bit base identifier
//   IDF_EX    : 18-bit extended identifier (0 for standard frames)
//   IDE       : captured IDE bit
//   RTR       : captured RTR bit
//   F_IDF     : 0 = arbitration field complete, outputs valid
//   STUFF_ERR : one-clk pulse on a stuff violation
// -----------------------------------------------------------------------------
module can_arb_deserializer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SP,
  input  logic                     RX,
  output logic [CAN_BASE_ID_W-1:0] IDF,
  output logic [CAN_EXT_ID_W-1:0]  IDF_EX,
  output logic                     IDE,
  output logic                     RTR,
  output logic                     F_IDF,
  output logic                     STUFF_ERR
);

  localparam int                IDLE_W    = $clog2(IDLE_BITS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

  can_state_e                 r_state;
  logic [IDLE_W-1:0]          r_idle_cnt;
  logic [CAN_BIT_CNT_W-1:0]   r_bit_cnt;
  logic [CAN_BASE_ID_W-1:0]   r_idf;
  logic [CAN_EXT_ID_W-1:0]    r_idf_ex;
  logic                       r_ide;
  logic                       r_rtr;
  logic                       r_srr;
  logic                       r_f_idf;
  logic                       r_stuff_err;

  logic w_seed;
  logic w_active;
  logic w_dv;
  logic w_viol;

  assign w_seed   = (r_state == ST_IDLE) & ~RX;
  assign w_active = (r_state == ST_BASE) | (r_state == ST_EXT);

  can_destuffer u_destuffer (
    .clk          (clk),
    .reset        (reset),
    .i_sp         (SP),
    .i_rx         (RX),
    .i_seed       (w_seed),
    .i_active     (w_active),
    .o_data_valid (w_dv),
    .o_stuff_viol (w_viol)
  );

  // Frame state machine, idle counter and arbitration-field capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT_IDLE;
      r_idle_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_idf       <= '0;
      r_idf_ex    <= '0;
      r_ide       <= 1'b0;
      r_rtr       <= 1'b0;
      r_srr       <= 1'b0;
      r_f_idf     <= 1'b1;
      r_stuff_err <= 1'b0;
    end else begin
      r_stuff_err <= 1'b0;
      if (SP) begin
        case (r_state)
          // Both states wait for IDLE_BITS recessive samples in a row;
          // DONE keeps the captured outputs while doing so
          ST_WAIT_IDLE, ST_DONE: begin
            if (RX) begin
              if (r_idle_cnt == IDLE_LAST) begin
                r_idle_cnt <= '0;
                r_state    <= ST_IDLE;
              end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
              end
            end else begin
              r_idle_cnt <= '0;
            end
          end

          ST_IDLE: begin
            if (!RX) begin
              r_state   <= ST_BASE;
              r_f_idf   <= 1'b1;
              r_bit_cnt <= '0;
              r_idf     <= '0;
              r_idf_ex  <= '0;
              r_srr     <= 1'b0;
            end
          end

          ST_BASE: begin
            if (w_viol) begin
              r_stuff_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
              r_idle_cnt  <= '0;
            end else if (w_dv) begin
              if (r_bit_cnt < CAN_POS_SRR) begin
                r_idf <= {r_idf[CAN_BASE_ID_W-2:0], RX};
              end else if (r_bit_cnt == CAN_POS_SRR) begin
                // RTR for standard frames, SRR for extended ones; decided by IDE
                r_srr <= RX;
              end else begin
                r_ide <= RX;
                if (RX) begin
                  r_state <= ST_EXT;
                end else begin
                  r_rtr      <= r_srr;
                  r_idf_ex   <= '0;
                  r_f_idf    <= 1'b0;
                  r_idle_cnt <= '0;
                  r_state    <= ST_DONE;
                end
              end
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end

          ST_EXT: begin
            if (w_viol) begin
              r_stuff_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
              r_idle_cnt  <= '0;
            end else if (w_dv) begin
              if (r_bit_cnt < CAN_POS_RTR_EXT) begin
                r_idf_ex  <= {r_idf_ex[CAN_EXT_ID_W-2:0], RX};
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end else begin
                r_rtr      <= RX;
                r_f_idf    <= 1'b0;
                r_idle_cnt <= '0;
                r_state    <= ST_DONE;
              end
            end
          end

          default: begin
            r_state    <= ST_WAIT_IDLE;
            r_idle_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign IDF       = r_idf;
  assign IDF_EX    = r_idf_ex;
  assign IDE       = r_ide;
  assign RTR       = r_rtr;
  assign F_IDF     = r_f_idf;
  assign STUFF_ERR = r_stuff_err;

endmodule
